imm_ext_pipe: RTL
=================

// Module: imm_ext_pipe
// PURPOSE
//  Parametrised, pipelined immediate extractor/extender for the 5-stage LEGv8 datapath.
//  Pulls the immediate field for a selected instruction format out of a 32-bit instruction.
//  Sign- or zero-extends it to DATA_W bits and applies the format's shift (<<2 or <<16*hw).
//  Sits between decode and the ALU-B/branch-target mux. Two register stages, valid/ready on
//  both sides, flush support.
// PARAMETERS
//  DATA_W  64  output width; legal values 32 or 64 only
//  TAG_W   5   width of sideband tag carried alongside (e.g. dest reg / ROB id)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-low reset (0 = reset)
//  flush      in   1       kill all in-flight entries (synchronous)
//  in_valid   in   1       upstream has an instruction
//  in_ready   out  1       block accepts this cycle
//  in_insn    in   32      instruction word
//  in_fmt     in   3       0=I 1=D 2=CB 3=B 4=IW; 5..7 illegal
//  in_tag     in   TAG_W   sideband, passed through unmodified
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts
//  out_imm    out  DATA_W  extended immediate
//  out_tag    out  TAG_W   tag of this result
//  out_err    out  1       illegal fmt or shift not representable in DATA_W
// BEHAVIOUR
//  Reset (reset==0 at posedge): s1_valid=s2_valid=0; out_valid=0, out_imm=0, out_tag=0, out_err=0.
//  Handshake: transfer on in_valid&in_ready / out_valid&out_ready. in_ready=!s1_valid|s1_adv.
//   s1_adv=!s2_valid|out_ready. No combinational path in_valid->out_valid.
//   out_imm/out_tag/out_err held stable while out_valid&!out_ready.
//  Stage 1 (capture): registers insn, fmt and tag. Extracts raw field and hw=insn[22:21].
//  Stage 2 (extend):
//   I : insn[21:10] zero-extended, no shift
//   D : insn[20:12] sign-extended (bit 20 replicated)
//   CB: insn[23:5] sign-extended, then <<2 (bits [1:0]=0)
//   B : insn[25:0] sign-extended, then <<2
//   IW: insn[20:5] zero-extended, then <<(16*hw)
//   Sign extension uses the field MSB before shifting. Shift bits beyond DATA_W are discarded.
//  Errors: fmt 5..7 -> out_imm=0, out_err=1.
//   IW with DATA_W=32 and hw>=2 -> out_imm=0, out_err=1.
//   An error result still flows through the handshake as a normal token; it is never dropped.
//  Latency: 2 cycles from accept to out_valid when out_ready=1. Throughput 1/cycle.
//  Backpressure: out_ready=0 with both stages full -> in_ready=0; no entry lost or duplicated.
//  Flush: s1_valid, s2_valid <= 0 next edge. in_ready forced 0 during the flush cycle, so an
//   input presented in that cycle is not accepted. Flush beats a simultaneous accept.
//  Reset mid-stream: behaves as flush plus clears data regs. Reset has priority over flush.
//  Simultaneous drain+fill: when both stages are full and out_ready=1, a new input is accepted
//   the same cycle (full pipelining).
// TESTING
//  I  insn[21:10]=12'hFFF, DATA_W=64 -> out_imm=64'h0000_0000_0000_0FFF, out_err=0.
//   Output 2 cycles after accept.
//  D  insn[20:12]=9'h100 -> 64'hFFFF_FFFF_FFFF_FF00.
//   CB insn[23:5]=19'h40000 -> 64'hFFFF_FFFF_FFF0_0000.
//  B  insn[25:0]=26'h1 -> 64'h4; insn[25:0]=26'h3FFFFFF -> 64'hFFFF_FFFF_FFFF_FFFC.
//  IW insn[20:5]=16'hBEEF, hw=3 -> 64'hBEEF_0000_0000_0000.
//   With DATA_W=32, hw=2 -> out_imm=0, out_err=1.
//  Backpressure: stream 5 tagged inputs (tags 1..5) with out_ready=0 for 4 cycles.
//   -> in_ready drops after 2 accepts. All 5 tags emerge in order, no drop or duplicate.
//  Flush with both stages full -> out_valid=0 next cycle. Input offered during flush not taken.
//   Reset=0 mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate extractor pipeline.
// master drives instructions in and accepts results; slave is the pipe.
interface imm_ext_pipe_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_insn;
    logic [2:0]        in_fmt;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_insn, in_fmt, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_insn, in_fmt, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Two-stage LEGv8 immediate extractor/extender.
// Stage 1 captures the instruction, stage 2 holds the extended result.
module imm_ext_pipe #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_ext_pipe_if.slave bus
);
    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_D  = 3'd1;
    localparam logic [2:0] FMT_CB = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_IW = 3'd4;

    logic              s1_valid_q, s1_valid_d;
    logic [25:0]       s1_insn_q, s1_insn_d;
    logic [2:0]        s1_fmt_q, s1_fmt_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_imm_q, s2_imm_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic              s2_err_q, s2_err_d;

    logic              s1_adv;
    logic              accept;
    logic [1:0]        hw;
    logic [DATA_W-1:0] ext_imm;
    logic              ext_err;

    assign s1_adv       = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !flush && (!s1_valid_q || s1_adv);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hw           = s1_insn_q[22:21];

    // Extract and extend the field selected by the captured format
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        unique case (s1_fmt_q)
            FMT_I:  ext_imm = {{(DATA_W-12){1'b0}}, s1_insn_q[21:10]};
            FMT_D:  ext_imm = {{(DATA_W-9){s1_insn_q[20]}}, s1_insn_q[20:12]};
            FMT_CB: ext_imm = {{(DATA_W-21){s1_insn_q[23]}},
                               s1_insn_q[23:5], 2'b00};
            FMT_B:  ext_imm = {{(DATA_W-28){s1_insn_q[25]}},
                               s1_insn_q[25:0], 2'b00};
            FMT_IW: begin
                ext_imm = DATA_W'({48'd0, s1_insn_q[20:5]} << {hw, 4'b0000});
                ext_err = (DATA_W == 32) && hw[1];
            end
            default: ext_err = 1'b1;
        endcase
        if (ext_err) begin
            ext_imm = '0;
        end
    end

    // Next-state for both stages: flush kills, stalls hold, advances shift
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_insn_d  = s1_insn_q;
        s1_fmt_d   = s1_fmt_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_imm_d = ext_imm;
                s2_tag_d = s1_tag_q;
                s2_err_d = ext_err;
            end
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_insn_d  = bus.in_insn[25:0];
            s1_fmt_d   = bus.in_fmt;
            s1_tag_d   = bus.in_tag;
        end
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset also clears the data path
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_insn_q  <= '0;
            s1_fmt_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_insn_q  <= s1_insn_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_imm   = s2_imm_q;
    assign bus.out_tag   = s2_tag_q;
    assign bus.out_err   = s2_err_q;
endmodule
